// File: rtl/result_checker_pkg.sv
// Shared types and widths for the result checker: FSM state encoding,
// SRAM address/data widths and a small helper for sizing counters.
package result_checker_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_IDLE = 3'd1,
        RUN       = 3'd2,
        COMPUTE   = 3'd3,
        SETTLE    = 3'd4,
        READ      = 3'd5,
        DONE      = 3'd6
    } rc_state_t;

    // Larger of two integers; used to size a counter shared by two waits.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/result_checker_if.sv
// Bundle between the result checker and the accelerator under test:
// run/busy handshake plus the output-SRAM and golden-SRAM read ports.
// The checker is the master; the accelerator and memories are the slave.
interface result_checker_if;
    import result_checker_pkg::*;

    logic              dut_run;
    logic              dut_busy;
    logic [ADDR_W-1:0] res_read_address;
    logic [DATA_W-1:0] res_read_data;
    logic [ADDR_W-1:0] gold_read_address;
    logic [DATA_W-1:0] gold_read_data;

    modport master (
        output dut_run,
        output res_read_address,
        output gold_read_address,
        input  dut_busy,
        input  res_read_data,
        input  gold_read_data
    );

    modport slave (
        input  dut_run,
        input  res_read_address,
        input  gold_read_address,
        output dut_busy,
        output res_read_data,
        output gold_read_data
    );

endinterface

// File: rtl/rc_cmp_stage.sv
// Compare stage of the readback: receives the issue valid/index delayed by
// one cycle to line up with the SRAM read latency, compares the result word
// against the golden word and accumulates the round statistics.
module rc_cmp_stage
    import result_checker_pkg::*;
#(
    parameter int NUM_RESULT = 96
)(
    input  logic              clk,
    input  logic              reset_b,
    input  logic              clear,
    input  logic              cmp_valid,
    input  logic [ADDR_W-1:0] cmp_index,
    input  logic [DATA_W-1:0] res_data,
    input  logic [DATA_W-1:0] gold_data,
    output logic [ADDR_W-1:0] correct_count,
    output logic              mismatch_seen,
    output logic [ADDR_W-1:0] first_mismatch
);

    localparam logic [ADDR_W-1:0] COUNT_MAX = ADDR_W'(NUM_RESULT);

    logic [DATA_W-1:0] diff_bits;
    logic              word_equal;
    logic [ADDR_W-1:0] correct_count_reg;
    logic              mismatch_seen_reg;
    logic [ADDR_W-1:0] first_mismatch_reg;

    // Per-bit difference between result and golden word.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_diff
        assign diff_bits[gi] = res_data[gi] ^ gold_data[gi];
    end

    assign word_equal = ~|diff_bits;

    // Accumulate matches (saturating) and latch the lowest differing index.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            correct_count_reg  <= '0;
            mismatch_seen_reg  <= 1'b0;
            first_mismatch_reg <= '0;
        end else if (clear) begin
            correct_count_reg  <= '0;
            mismatch_seen_reg  <= 1'b0;
            first_mismatch_reg <= '0;
        end else if (cmp_valid) begin
            if (word_equal) begin
                if (correct_count_reg < COUNT_MAX) begin
                    correct_count_reg <= correct_count_reg + 1'b1;
                end
            end else if (!mismatch_seen_reg) begin
                mismatch_seen_reg  <= 1'b1;
                first_mismatch_reg <= cmp_index;
            end
        end
    end

    assign correct_count  = correct_count_reg;
    assign mismatch_seen  = mismatch_seen_reg;
    assign first_mismatch = first_mismatch_reg;

endmodule

// File: rtl/result_checker.sv
// On-chip self-test result checker: launches the accelerator, measures how
// long it stays busy, then streams the output SRAM and golden SRAM side by
// side through a one-cycle compare stage. Every wait state is guarded by a
// timeout that ends the round without a readback.
module result_checker
    import result_checker_pkg::*;
#(
    parameter int NUM_RESULT     = 96,
    parameter int SETTLE_CYCLES  = 10,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 32
)(
    input  logic                clk,
    input  logic                reset_b,
    input  logic                start,
    output logic                done,
    output logic                timeout,
    result_checker_if.master    bus,
    output logic [ADDR_W-1:0]   correct_count,
    output logic                mismatch_seen,
    output logic [ADDR_W-1:0]   first_mismatch,
    output logic [CNT_W-1:0]    compute_cycles
);

    // One counter serves both the timeout guard and the settle delay.
    localparam int WAIT_MAX = max_int(TIMEOUT_CYCLES, SETTLE_CYCLES);
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int IDX_W    = ADDR_W + 1;

    localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] SETTLE_LAST  = WAIT_W'(SETTLE_CYCLES - 1);
    // rd_idx runs one past the last issue so the final compare can land.
    localparam logic [IDX_W-1:0]  READ_LAST    = IDX_W'(NUM_RESULT);
    localparam logic [ADDR_W-1:0] ADDR_LAST    = ADDR_W'(NUM_RESULT - 1);

    rc_state_t          state_reg, state_next;
    logic               dut_run_reg, dut_run_next;
    logic               done_reg, done_next;
    logic               timeout_reg, timeout_next;
    logic               run_ack_reg, run_ack_next;
    logic               round_clear;
    logic [WAIT_W-1:0]  wait_cnt_reg;
    logic               wait_expired;
    logic               settle_done;
    logic               cycle_count_en;
    logic [CNT_W-1:0]   compute_cycles_reg;
    logic [IDX_W-1:0]   rd_idx_reg;
    logic               issue_valid;
    logic               cmp_valid_reg;
    logic [ADDR_W-1:0]  cmp_index_reg;
    logic [ADDR_W-1:0]  read_address;

    assign wait_expired = (wait_cnt_reg == TIMEOUT_LAST);
    assign settle_done  = (wait_cnt_reg == SETTLE_LAST);

    // State and handshake registers; reset drops dut_run without a clock.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_reg   <= IDLE;
            dut_run_reg <= 1'b0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            run_ack_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dut_run_reg <= dut_run_next;
            done_reg    <= done_next;
            timeout_reg <= timeout_next;
            run_ack_reg <= run_ack_next;
        end
    end

    // Next-state logic: launch, busy tracking, settle, readback, timeouts.
    always_comb begin
        state_next   = state_reg;
        dut_run_next = dut_run_reg;
        done_next    = done_reg;
        timeout_next = timeout_reg;
        run_ack_next = 1'b0;
        round_clear  = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    round_clear  = 1'b1;
                    done_next    = 1'b0;
                    timeout_next = 1'b0;
                    state_next   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!bus.dut_busy) begin
                    dut_run_next = 1'b1;
                    state_next   = RUN;
                end else if (wait_expired) begin
                    timeout_next = 1'b1;
                    done_next    = 1'b1;
                    state_next   = DONE;
                end
            end
            RUN: begin
                // Busy is acknowledged on one edge; run drops on the next.
                if (run_ack_reg) begin
                    dut_run_next = 1'b0;
                    state_next   = COMPUTE;
                end else if (bus.dut_busy) begin
                    run_ack_next = 1'b1;
                end else if (wait_expired) begin
                    dut_run_next = 1'b0;
                    timeout_next = 1'b1;
                    done_next    = 1'b1;
                    state_next   = DONE;
                end
            end
            COMPUTE: begin
                if (!bus.dut_busy) begin
                    state_next = SETTLE;
                end else if (wait_expired) begin
                    timeout_next = 1'b1;
                    done_next    = 1'b1;
                    state_next   = DONE;
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (rd_idx_reg == READ_LAST) begin
                    done_next  = 1'b1;
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-state wait counter, restarted on every state change.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wait_cnt_reg <= '0;
        end else if (state_next != state_reg) begin
            wait_cnt_reg <= '0;
        end else if (wait_cnt_reg != {WAIT_W{1'b1}}) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

    // Counts from the launch edge through the edge that sees busy fall.
    assign cycle_count_en = ((state_reg == WAIT_IDLE) && (state_next == RUN)) ||
                            (state_reg == RUN) || (state_reg == COMPUTE);

    // Saturating compute-cycle counter.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            compute_cycles_reg <= '0;
        end else if (round_clear) begin
            compute_cycles_reg <= '0;
        end else if (cycle_count_en && (compute_cycles_reg != {CNT_W{1'b1}})) begin
            compute_cycles_reg <= compute_cycles_reg + 1'b1;
        end
    end

    // Readback index: one address per cycle, then parks one past the end.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rd_idx_reg <= '0;
        end else if (round_clear) begin
            rd_idx_reg <= '0;
        end else if ((state_reg == READ) && (rd_idx_reg != READ_LAST)) begin
            rd_idx_reg <= rd_idx_reg + 1'b1;
        end
    end

    assign issue_valid  = (state_reg == READ) && (rd_idx_reg < READ_LAST);
    assign read_address = (rd_idx_reg == READ_LAST) ? ADDR_LAST : rd_idx_reg[ADDR_W-1:0];

    // Delay issue valid/index by the SRAM read latency.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cmp_valid_reg <= 1'b0;
            cmp_index_reg <= '0;
        end else begin
            cmp_valid_reg <= issue_valid;
            cmp_index_reg <= rd_idx_reg[ADDR_W-1:0];
        end
    end

    rc_cmp_stage #(
        .NUM_RESULT (NUM_RESULT)
    ) u_cmp_stage (
        .clk            (clk),
        .reset_b        (reset_b),
        .clear          (round_clear),
        .cmp_valid      (cmp_valid_reg),
        .cmp_index      (cmp_index_reg),
        .res_data       (bus.res_read_data),
        .gold_data      (bus.gold_read_data),
        .correct_count  (correct_count),
        .mismatch_seen  (mismatch_seen),
        .first_mismatch (first_mismatch)
    );

    assign bus.dut_run           = dut_run_reg;
    assign bus.res_read_address  = read_address;
    assign bus.gold_read_address = read_address;
    assign done                  = done_reg;
    assign timeout               = timeout_reg;
    assign compute_cycles        = compute_cycles_reg;

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker: instance A (96 words, long busy) and
// instance B (144 words, 100-cycle timeout) with behavioural accelerator
// busy models and 1-cycle-latency SRAM models.
module tb_result_checker;
    import result_checker_pkg::*;

    localparam int NUM_A = 96;
    localparam int NUM_B = 144;

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic              done_a, timeout_a, mismatch_seen_a;
    logic [ADDR_W-1:0] correct_count_a, first_mismatch_a;
    logic [31:0]       compute_cycles_a;
    logic              done_b, timeout_b, mismatch_seen_b;
    logic [ADDR_W-1:0] correct_count_b, first_mismatch_b;
    logic [31:0]       compute_cycles_b;

    result_checker_if bus_a();
    result_checker_if bus_b();

    int n_checks = 0;
    int n_errors = 0;
    int busy_len_a = 0;
    int busy_len_b = 0;
    int left_a = 0;
    int left_b = 0;
    bit launched_a = 0;
    bit launched_b = 0;
    int cyc;
    bit seen;

    logic [DATA_W-1:0] res_mem_a  [0:4095];
    logic [DATA_W-1:0] gold_mem_a [0:4095];
    logic [DATA_W-1:0] res_mem_b  [0:4095];
    logic [DATA_W-1:0] gold_mem_b [0:4095];

    always #5 clk = ~clk;

    result_checker #(.NUM_RESULT(NUM_A)) u_dut_a (
        .clk            (clk),
        .reset_b        (reset_b),
        .start          (start_a),
        .done           (done_a),
        .timeout        (timeout_a),
        .bus            (bus_a),
        .correct_count  (correct_count_a),
        .mismatch_seen  (mismatch_seen_a),
        .first_mismatch (first_mismatch_a),
        .compute_cycles (compute_cycles_a)
    );

    result_checker #(.NUM_RESULT(NUM_B), .TIMEOUT_CYCLES(100)) u_dut_b (
        .clk            (clk),
        .reset_b        (reset_b),
        .start          (start_b),
        .done           (done_b),
        .timeout        (timeout_b),
        .bus            (bus_b),
        .correct_count  (correct_count_b),
        .mismatch_seen  (mismatch_seen_b),
        .first_mismatch (first_mismatch_b),
        .compute_cycles (compute_cycles_b)
    );

    // SRAM models with one cycle of read latency.
    always @(posedge clk) begin
        bus_a.res_read_data  <= res_mem_a[bus_a.res_read_address];
        bus_a.gold_read_data <= gold_mem_a[bus_a.gold_read_address];
        bus_b.res_read_data  <= res_mem_b[bus_b.res_read_address];
        bus_b.gold_read_data <= gold_mem_b[bus_b.gold_read_address];
    end

    // Accelerator models: on seeing run, stay busy for busy_len sampled edges.
    always @(negedge clk) begin
        if (!reset_b) begin
            left_a = 0; launched_a = 0; bus_a.dut_busy = 1'b0;
            left_b = 0; launched_b = 0; bus_b.dut_busy = 1'b0;
        end else begin
            if (!bus_a.dut_run) launched_a = 0;
            if (bus_a.dut_run && !launched_a) begin launched_a = 1; left_a = busy_len_a; end
            bus_a.dut_busy = (left_a > 0);
            if (left_a > 0) left_a--;
            if (!bus_b.dut_run) launched_b = 0;
            if (bus_b.dut_run && !launched_b) begin launched_b = 1; left_b = busy_len_b; end
            bus_b.dut_busy = (left_b > 0);
            if (left_b > 0) left_b--;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input bit inst_b);
        @(negedge clk);
        if (inst_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Wait for done with a cycle budget; also note any nonzero read address.
    task automatic wait_done(input bit inst_b, input int budget, output int cycles, output bit addr_seen);
        cycles = 0;
        addr_seen = 0;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            if (inst_b ? (bus_b.res_read_address != 0 || bus_b.gold_read_address != 0)
                       : (bus_a.res_read_address != 0 || bus_a.gold_read_address != 0))
                addr_seen = 1;
            if ((inst_b ? done_b : done_a) == 1'b1) begin
                cycles = k;
                break;
            end
        end
        if (cycles == 0) check("done_within_bound", {31'b0, inst_b ? done_b : done_a}, 32'd1);
    endtask

    task automatic log_round(input string tag, input bit inst_b, input int cycles);
        if (inst_b)
            $display("round %s: latency=%0d count=%0d mismatch=%0d first=0x%03h cycles=%0d timeout=%0d",
                     tag, cycles, correct_count_b, mismatch_seen_b, first_mismatch_b, compute_cycles_b, timeout_b);
        else
            $display("round %s: latency=%0d count=%0d mismatch=%0d first=0x%03h cycles=%0d timeout=%0d",
                     tag, cycles, correct_count_a, mismatch_seen_a, first_mismatch_a, compute_cycles_a, timeout_a);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            gold_mem_a[i] = 16'(i * 37 + 16'h00a5);
            res_mem_a[i]  = 16'(i * 37 + 16'h00a5);
            gold_mem_b[i] = 16'(i * 53 + 16'h1234);
            res_mem_b[i]  = 16'(i * 53 + 16'h1234);
        end
        busy_len_a = 500;
        busy_len_b = 20;

        // Reset state
        #12;
        check("rst_done_a", {31'b0, done_a}, 32'd0);
        check("rst_timeout_a", {31'b0, timeout_a}, 32'd0);
        check("rst_dut_run_a", {31'b0, bus_a.dut_run}, 32'd0);
        check("rst_count_a", {20'b0, correct_count_a}, 32'd0);
        check("rst_mismatch_a", {31'b0, mismatch_seen_a}, 32'd0);
        check("rst_cycles_a", compute_cycles_a, 32'd0);
        check("rst_addr_a", {20'b0, bus_a.res_read_address}, 32'd0);
        check("rst_done_b", {31'b0, done_b}, 32'd0);
        @(negedge clk);
        reset_b = 1'b1;

        // Clean round, busy 500 cycles
        pulse_start(0);
        wait_done(0, 2000, cyc, seen);
        log_round("a_clean", 0, cyc);
        check("a1_latency", cyc, 32'd609);
        check("a1_count", {20'b0, correct_count_a}, 32'd96);
        check("a1_mismatch", {31'b0, mismatch_seen_a}, 32'd0);
        check("a1_cycles", compute_cycles_a, 32'd502);
        check("a1_done", {31'b0, done_a}, 32'd1);
        check("a1_timeout", {31'b0, timeout_a}, 32'd0);
        check("a1_dut_run", {31'b0, bus_a.dut_run}, 32'd0);
        check("a1_res_addr_hold", {20'b0, bus_a.res_read_address}, 32'd95);
        check("a1_gold_addr_hold", {20'b0, bus_a.gold_read_address}, 32'd95);

        // Last word corrupted
        res_mem_a[12'h05f] = 16'hffff;
        pulse_start(0);
        wait_done(0, 2000, cyc, seen);
        log_round("a_miss_5f", 0, cyc);
        check("a2_count", {20'b0, correct_count_a}, 32'd95);
        check("a2_mismatch", {31'b0, mismatch_seen_a}, 32'd1);
        check("a2_first", {20'b0, first_mismatch_a}, 32'h05f);
        check("a2_cycles", compute_cycles_a, 32'd502);

        // Word 0 corrupted too: lowest index wins
        res_mem_a[0] = ~gold_mem_a[0];
        pulse_start(0);
        wait_done(0, 2000, cyc, seen);
        log_round("a_miss_0_5f", 0, cyc);
        check("a3_count", {20'b0, correct_count_a}, 32'd94);
        check("a3_first", {20'b0, first_mismatch_a}, 32'h000);
        res_mem_a[0] = gold_mem_a[0];
        res_mem_a[12'h05f] = gold_mem_a[12'h05f];

        // start during COMPUTE is ignored
        pulse_start(0);
        repeat (200) @(posedge clk);
        pulse_start(0);
        wait_done(0, 2000, cyc, seen);
        log_round("a_start_in_compute", 0, cyc);
        check("a4_cycles", compute_cycles_a, 32'd502);
        check("a4_count", {20'b0, correct_count_a}, 32'd96);
        check("a4_mismatch", {31'b0, mismatch_seen_a}, 32'd0);

        // Reset mid-COMPUTE, asynchronously, then a fresh round
        pulse_start(0);
        repeat (100) @(posedge clk);
        #3;
        check("a5_pre_reset_cycles", compute_cycles_a, 32'd100);
        reset_b = 1'b0;
        #1;
        check("a5_rst_dut_run", {31'b0, bus_a.dut_run}, 32'd0);
        check("a5_rst_cycles", compute_cycles_a, 32'd0);
        check("a5_rst_done", {31'b0, done_a}, 32'd0);
        check("a5_rst_count", {20'b0, correct_count_a}, 32'd0);
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        busy_len_a = 30;
        pulse_start(0);
        wait_done(0, 2000, cyc, seen);
        log_round("a_after_reset", 0, cyc);
        check("a5_cycles", compute_cycles_a, 32'd32);
        check("a5_count", {20'b0, correct_count_a}, 32'd96);
        check("a5_done", {31'b0, done_a}, 32'd1);

        // Timeout: DUT never raises busy
        busy_len_b = 0;
        pulse_start(1);
        wait_done(1, 500, cyc, seen);
        log_round("b_timeout", 1, cyc);
        check("b6_latency", cyc, 32'd101);
        check("b6_timeout", {31'b0, timeout_b}, 32'd1);
        check("b6_done", {31'b0, done_b}, 32'd1);
        check("b6_dut_run", {31'b0, bus_b.dut_run}, 32'd0);
        check("b6_count", {20'b0, correct_count_b}, 32'd0);
        check("b6_mismatch", {31'b0, mismatch_seen_b}, 32'd0);
        check("b6_addr_seen", {31'b0, seen}, 32'd0);
        check("b6_res_addr", {20'b0, bus_b.res_read_address}, 32'd0);

        // Reset while in RUN drops dut_run without a clock edge
        pulse_start(1);
        repeat (50) @(posedge clk);
        #3;
        check("b7_run_high", {31'b0, bus_b.dut_run}, 32'd1);
        reset_b = 1'b0;
        #1;
        check("b7_rst_dut_run", {31'b0, bus_b.dut_run}, 32'd0);
        check("b7_rst_timeout", {31'b0, timeout_b}, 32'd0);
        repeat (2) @(negedge clk);
        reset_b = 1'b1;

        // Back-to-back rounds, mismatch in the first only
        busy_len_b = 20;
        res_mem_b[12'h08f] = 16'hffff;
        pulse_start(1);
        wait_done(1, 1000, cyc, seen);
        log_round("b_round1", 1, cyc);
        check("b8_latency", cyc, 32'd177);
        check("b8_count", {20'b0, correct_count_b}, 32'd143);
        check("b8_mismatch", {31'b0, mismatch_seen_b}, 32'd1);
        check("b8_first", {20'b0, first_mismatch_b}, 32'h08f);
        check("b8_cycles", compute_cycles_b, 32'd22);
        check("b8_addr_hold", {20'b0, bus_b.res_read_address}, 32'd143);
        res_mem_b[12'h08f] = gold_mem_b[12'h08f];
        pulse_start(1);
        wait_done(1, 1000, cyc, seen);
        log_round("b_round2", 1, cyc);
        check("b9_count", {20'b0, correct_count_b}, 32'd144);
        check("b9_mismatch", {31'b0, mismatch_seen_b}, 32'd0);
        check("b9_first", {20'b0, first_mismatch_b}, 32'd0);
        check("b9_cycles", compute_cycles_b, 32'd22);
        check("b9_done", {31'b0, done_b}, 32'd1);
        check("b9_timeout", {31'b0, timeout_b}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
